cache_nway: RTL and testbench

Parametrised N-way set-associative cache storage array with true-LRU replacement, block fills and a full-cache flush sequencer. It is the next generation of the 2-way cache array and is controlled by the same cache controller FSM through load/edit/store/invalid strobes. It adds configurable way/set/block geometry, an explicit victim way and a multi-cycle `flush_all` sweep with a `busy` handshake.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/cache_lru.sv | 44 ++++
 rtl/cache_nway.sv | 212 +++++++++++++++++++++
 tb/tb_cache_nway.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the N-way cache array: access-size encodings,
// flush sequencer states and address-field geometry helpers.
package cache_pkg;

  // u_b_h_w encodings: bit1 = word, bit0 = half (else byte), bit2 = unsigned
  localparam logic [2:0] UBHW_LB  = 3'b000;
  localparam logic [2:0] UBHW_LH  = 3'b001;
  localparam logic [2:0] UBHW_LW  = 3'b010;
  localparam logic [2:0] UBHW_LBU = 3'b100;
  localparam logic [2:0] UBHW_LHU = 3'b101;

  // Flush sequencer states
  localparam logic [0:0] FL_IDLE  = 1'b0;
  localparam logic [0:0] FL_SWEEP = 1'b1;

  // Address layout is tag | set | word | byte[1:0]
  function automatic int tag_bits_f(int addr_bits, int set_bits, int wsel_bits);
    return addr_bits - set_bits - wsel_bits - 2;
  endfunction

  function automatic int set_lo_f(int wsel_bits);
    return 2 + wsel_bits;
  endfunction

  function automatic int tag_lo_f(int set_bits, int wsel_bits);
    return 2 + wsel_bits + set_bits;
  endfunction

endpackage

// File: rtl/cache_lru.sv
// True-LRU age update and victim selection for one set.
module cache_lru #(
  parameter int WAYS = 4,
  parameter int AW   = 2
) (
  input  logic [WAYS-1:0][AW-1:0] age_i,
  input  logic [WAYS-1:0]         valid_i,
  input  logic                    touch_i,
  input  logic [AW-1:0]           touch_way_i,
  output logic [WAYS-1:0][AW-1:0] age_o,
  output logic [AW-1:0]           victim_o
);

  logic found;

  // Victim: lowest invalid way, else the oldest (age == WAYS-1)
  always_comb begin
    victim_o = '0;
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (!valid_i[w] && !found) begin
        victim_o = AW'(w);
        found    = 1'b1;
      end
    end
    if (!found) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w] == AW'(WAYS - 1)) victim_o = AW'(w);
      end
    end
  end

  // Touch: younger-than-h ways age by one, h becomes youngest
  always_comb begin
    age_o = age_i;
    if (touch_i) begin
      for (int w = 0; w < WAYS; w++) begin
        if (age_i[w] < age_i[touch_way_i]) age_o[w] = age_i[w] + 1'b1;
      end
      age_o[touch_way_i] = '0;
    end
  end

endmodule

// File: rtl/cache_nway.sv
// N-way set-associative cache storage array with true-LRU replacement,
// word fills into the selected way and a whole-cache flush sweep.
module cache_nway import cache_pkg::*; #(
  parameter  int ADDR_BITS     = 32,
  parameter  int WAYS          = 4,
  parameter  int SET_BITS      = 5,
  parameter  int WORD_SEL_BITS = 2,
  localparam int TAG_BITS      = tag_bits_f(ADDR_BITS, SET_BITS, WORD_SEL_BITS),
  localparam int AW            = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 load,
  input  logic                 edit,
  input  logic                 store,
  input  logic                 invalid,
  input  logic                 flush_all,
  input  logic [2:0]           u_b_h_w,
  input  logic [31:0]          din,
  output logic                 hit,
  output logic [31:0]          dout,
  output logic                 valid,
  output logic                 dirty,
  output logic [TAG_BITS-1:0]  tag,
  output logic [AW-1:0]        victim_way,
  output logic                 busy
);

  localparam int SETS   = 1 << SET_BITS;
  localparam int WORDS  = 1 << WORD_SEL_BITS;
  localparam int SET_LO = set_lo_f(WORD_SEL_BITS);
  localparam int TAG_LO = tag_lo_f(SET_BITS, WORD_SEL_BITS);

  logic [SETS-1:0][WAYS-1:0]         valid_q, valid_d, dirty_q, dirty_d;
  logic [SETS-1:0][WAYS-1:0][AW-1:0] age_q, age_d;
  logic [TAG_BITS-1:0]               tag_mem  [SETS][WAYS];
  logic [31:0]                       data_mem [SETS][WAYS][WORDS];

  logic [0:0]          fl_state_q, fl_state_d;
  logic [SET_BITS-1:0] fl_cnt_q, fl_cnt_d;

  logic                hit_q, hit_d, sel_valid_q, sel_valid_d, sel_dirty_q, sel_dirty_d;
  logic [31:0]         dout_q, dout_d;
  logic [TAG_BITS-1:0] sel_tag_q, sel_tag_d;
  logic [AW-1:0]       victim_q, victim_d;

  logic [SET_BITS-1:0]      set_idx;
  logic [WORD_SEL_BITS-1:0] word_idx;
  logic [TAG_BITS-1:0]      addr_tag;

  assign set_idx  = addr[SET_LO +: SET_BITS];
  assign word_idx = addr[2 +: WORD_SEL_BITS];
  assign addr_tag = addr[TAG_LO +: TAG_BITS];
  assign busy     = (fl_state_q == FL_SWEEP);

  logic [WAYS-1:0] hit_vec;
  logic            hit_any;
  logic [AW-1:0]   hit_way, victim, sel_way;

  // Tag compare across the addressed set; lowest matching way wins
  always_comb begin
    hit_vec = '0;
    hit_any = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = valid_q[set_idx][w] && (tag_mem[set_idx][w] == addr_tag);
    end
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w] && !hit_any) begin
        hit_any = 1'b1;
        hit_way = AW'(w);
      end
    end
  end

  // Strobe decode: invalid > store > edit > load, all muted while sweeping
  logic do_inv, do_store, do_edit, load_hit, touch;
  assign do_inv   = !busy && invalid;
  assign do_store = !busy && !invalid && store;
  assign do_edit  = !busy && !invalid && !store && edit && hit_any;
  assign load_hit = !busy && !invalid && !store && !edit && load && hit_any;
  assign touch    = load_hit || do_edit;

  logic [WAYS-1:0][AW-1:0] lru_age;

  cache_lru #(.WAYS(WAYS), .AW(AW)) u_lru (
    .age_i       (age_q[set_idx]),
    .valid_i     (valid_q[set_idx]),
    .touch_i     (touch),
    .touch_way_i (hit_way),
    .age_o       (lru_age),
    .victim_o    (victim)
  );

  // A store that hits the block being filled keeps writing that way, so
  // later beats of a fill land beside the first one.
  assign sel_way = hit_any ? hit_way : victim;

  logic [31:0] sel_word, vic_word, sh_word, ld_data, ed_data;
  assign sel_word = data_mem[set_idx][sel_way][word_idx];
  assign vic_word = data_mem[set_idx][victim][word_idx];

  // RV32I load extraction and store-style merge on the selected word
  always_comb begin
    sh_word = sel_word >> {addr[1:0], 3'b000};
    if (u_b_h_w[1])      ld_data = sel_word;
    else if (u_b_h_w[0]) ld_data = {{16{sh_word[15] & ~u_b_h_w[2]}}, sh_word[15:0]};
    else                 ld_data = {{24{sh_word[7] & ~u_b_h_w[2]}}, sh_word[7:0]};
    ed_data = sel_word;
    if (u_b_h_w[1])      ed_data = din;
    else if (u_b_h_w[0]) ed_data[{addr[1], 4'b0000} +: 16] = din[15:0];
    else                 ed_data[{addr[1:0], 3'b000} +: 8] = din[7:0];
  end

  // Data/tag RAM writes: fills and edit hits (no reset on the RAMs)
  always_ff @(posedge clk) begin
    if (do_store || do_edit) data_mem[set_idx][sel_way][word_idx] <= do_store ? din : ed_data;
    if (do_store)            tag_mem[set_idx][sel_way] <= addr_tag;
  end

  // Next state of valid/dirty/age: the sweep owns the array while busy
  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    age_d   = age_q;
    if (busy) begin
      valid_d[fl_cnt_q] = '0;
      dirty_d[fl_cnt_q] = '0;
      for (int w = 0; w < WAYS; w++) age_d[fl_cnt_q][w] = AW'(w);
    end else begin
      if (do_inv) begin
        valid_d[set_idx] = '0;
        dirty_d[set_idx] = '0;
      end else if (do_store) begin
        valid_d[set_idx][sel_way] = 1'b1;
        dirty_d[set_idx][sel_way] = 1'b0;
      end else if (do_edit) begin
        dirty_d[set_idx][hit_way] = 1'b1;
      end
      if (touch) age_d[set_idx] = lru_age;
    end
  end

  // Flush sequencer: one set per cycle, SETS cycles total
  always_comb begin
    fl_state_d = fl_state_q;
    fl_cnt_d   = fl_cnt_q;
    if (fl_state_q == FL_IDLE) begin
      if (flush_all) begin
        fl_state_d = FL_SWEEP;
        fl_cnt_d   = '0;
      end
    end else begin
      fl_cnt_d = fl_cnt_q + 1'b1;
      if (fl_cnt_q == SET_BITS'(SETS - 1)) fl_state_d = FL_IDLE;
    end
  end

  // Registered response; tag of an invalid line reads as 0 so no stale RAM
  // contents leak out
  always_comb begin
    hit_d       = !busy && !invalid && !store && (load || edit) && hit_any;
    dout_d      = dout_q;
    if (!busy) begin
      if (!load)         dout_d = vic_word;
      else if (load_hit) dout_d = ld_data;
    end
    sel_valid_d = valid_q[set_idx][sel_way];
    sel_dirty_d = dirty_q[set_idx][sel_way];
    sel_tag_d   = sel_valid_d ? tag_mem[set_idx][sel_way] : '0;
    victim_d    = victim;
  end

  // State and output registers, async active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++) age_q[s][w] <= AW'(w);
      fl_state_q  <= FL_IDLE;
      fl_cnt_q    <= '0;
      hit_q       <= 1'b0;
      dout_q      <= '0;
      sel_valid_q <= 1'b0;
      sel_dirty_q <= 1'b0;
      sel_tag_q   <= '0;
      victim_q    <= '0;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      age_q       <= age_d;
      fl_state_q  <= fl_state_d;
      fl_cnt_q    <= fl_cnt_d;
      hit_q       <= hit_d;
      dout_q      <= dout_d;
      sel_valid_q <= sel_valid_d;
      sel_dirty_q <= sel_dirty_d;
      sel_tag_q   <= sel_tag_d;
      victim_q    <= victim_d;
    end
  end

  assign hit        = hit_q;
  assign dout       = dout_q;
  assign valid      = sel_valid_q;
  assign dirty      = sel_dirty_q;
  assign tag        = sel_tag_q;
  assign victim_way = victim_q;

endmodule

// File: tb/tb_cache_nway.sv
// Directed bench for cache_nway: fills, LRU replacement, edits, writeback
// read-out, invalidate, flush sweep length and reset during a sweep.
module tb_cache_nway;
  import cache_pkg::*;

  localparam logic [4:0] S_NONE = 5'b00000;
  localparam logic [4:0] S_LD   = 5'b00001;
  localparam logic [4:0] S_ED   = 5'b00010;
  localparam logic [4:0] S_ST   = 5'b00100;
  localparam logic [4:0] S_INV  = 5'b01000;
  localparam logic [4:0] S_FL   = 5'b10000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] addr = '0;
  logic        load = 1'b0, edit = 1'b0, store = 1'b0, invalid = 1'b0, flush_all = 1'b0;
  logic [2:0]  u_b_h_w = '0;
  logic [31:0] din = '0;
  logic        hit, valid, dirty, busy;
  logic [31:0] dout;
  logic [22:0] tag;
  logic [1:0]  victim_way;

  int n_chk = 0;
  int n_fail = 0;

  cache_nway dut (
    .clk(clk), .rst(rst), .addr(addr), .load(load), .edit(edit), .store(store),
    .invalid(invalid), .flush_all(flush_all), .u_b_h_w(u_b_h_w), .din(din),
    .hit(hit), .dout(dout), .valid(valid), .dirty(dirty), .tag(tag),
    .victim_way(victim_way), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // One request cycle; outputs are stable from here to the next edge
  task automatic op(input logic [4:0] s, input logic [31:0] a, input logic [2:0] sz,
                    input logic [31:0] d);
    {flush_all, invalid, store, edit, load} = s;
    addr = a; u_b_h_w = sz; din = d;
    @(posedge clk); #1;
    {flush_all, invalid, store, edit, load} = '0;
  endtask

  // Counts cycles busy is seen high, starting from the cycle after flush
  task automatic sweep_len(output int n);
    n = busy ? 1 : 0;
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
  endtask

  initial begin
    logic [31:0] a;
    int n;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_hit", hit, 0);
    chk("rst_dout", dout, 0);
    chk("rst_valid", valid, 0);
    chk("rst_dirty", dirty, 0);
    chk("rst_tag", tag, 0);
    chk("rst_victim", victim_way, 0);
    chk("rst_busy", busy, 0);

    op(S_LD, 32'h210, UBHW_LW, 0);
    chk("cold_hit", hit, 0);
    chk("cold_valid", valid, 0);
    chk("cold_victim", victim_way, 0);
    chk("cold_dout", dout, 0);

    // Fill four blocks of set 1, tags 1..4 into ways 0..3
    for (int b = 1; b <= 4; b++)
      for (int i = 0; i < 4; i++) begin
        a = b * 32'h200 + 32'h10 + i * 4;
        op(S_ST, a, UBHW_LW, a);
      end
    for (int b = 1; b <= 4; b++) begin
      a = b * 32'h200 + 32'h10;
      op(S_LD, a, UBHW_LW, 0);
      chk("fill_hit", hit, 1);
      chk("fill_dout", dout, a);
      chk("fill_tag", tag, b);
      op(S_LD, a + 12, UBHW_LW, 0);
      chk("fill_w3", dout, a + 12);
    end

    // LRU replacement: way 0 is oldest
    op(S_ST, 32'hA10, UBHW_LW, 32'hA10);
    chk("repl_victim", victim_way, 0);
    chk("repl_tag", tag, 1);
    chk("repl_dirty", dirty, 0);
    chk("repl_valid", valid, 1);
    op(S_LD, 32'hA10, UBHW_LW, 0);
    chk("repl_hit", hit, 1);
    chk("repl_dout", dout, 32'hA10);
    op(S_LD, 32'h210, UBHW_LW, 0);
    chk("evict_hit", hit, 0);
    chk("miss_hold", dout, 32'hA10);

    // Byte and half edits on way 2 (tag 3)
    op(S_ED, 32'h614, UBHW_LB, 32'hFF);
    chk("edit_hit", hit, 1);
    op(S_LD, 32'h614, UBHW_LB, 0);
    chk("lb_hit", hit, 1);
    chk("lb_dout", dout, 32'hFFFF_FFFF);
    chk("edit_dirty", dirty, 1);
    op(S_LD, 32'h614, UBHW_LBU, 0);
    chk("lbu_dout", dout, 32'h0000_00FF);
    op(S_LD, 32'h614, UBHW_LW, 0);
    chk("lw_dout", dout, 32'h0000_06FF);
    op(S_ED, 32'h61A, UBHW_LH, 32'h8001);
    op(S_LD, 32'h61A, UBHW_LH, 0);
    chk("lh_dout", dout, 32'hFFFF_8001);
    op(S_LD, 32'h61A, UBHW_LHU, 0);
    chk("lhu_dout", dout, 32'h0000_8001);
    op(S_LD, 32'h618, UBHW_LW, 0);
    chk("lw2_dout", dout, 32'h8001_0618);
    op(S_ED, 32'hC14, UBHW_LB, 32'h11);
    chk("edit_miss", hit, 0);

    // Idle cycle on a missing tag: ages now w0=1 w1=3 w2=0 w3=2
    op(S_NONE, 32'hC18, UBHW_LW, 0);
    chk("wb_hit", hit, 0);
    chk("wb_victim", victim_way, 1);
    chk("wb_tag", tag, 2);
    chk("wb_dout", dout, 32'h418);

    // Invalidate whole set 1
    op(S_INV, 32'h610, UBHW_LW, 0);
    op(S_LD, 32'h614, UBHW_LW, 0);
    chk("inv_hit", hit, 0);
    chk("inv_valid", valid, 0);
    chk("inv_victim", victim_way, 0);

    op(S_ST, 32'h820, UBHW_LW, 32'h55);
    op(S_LD, 32'h820, UBHW_LW, 0);
    chk("pre_fl_hit", hit, 1);
    chk("pre_fl_dout", dout, 32'h55);

    // Full flush, with a load mid-sweep
    op(S_FL, 0, UBHW_LW, 0);
    chk("fl_busy", busy, 1);
    op(S_LD, 32'h820, UBHW_LW, 0);
    chk("fl_ld_hit", hit, 0);
    n = 2;
    for (int k = 0; k < 100 && busy; k++) begin
      @(posedge clk); #1;
      if (busy) n++;
    end
    chk("fl_len", n, 32);
    op(S_ST, 32'h820, UBHW_LW, 32'h77);
    op(S_LD, 32'h810, UBHW_LW, 0);
    chk("post_fl_810", hit, 0);
    op(S_LD, 32'hA10, UBHW_LW, 0);
    chk("post_fl_A10", hit, 0);
    op(S_LD, 32'h820, UBHW_LW, 0);
    chk("fall_store_hit", hit, 1);
    chk("fall_store_dout", dout, 32'h77);

    // Reset during sweep cycle 10
    op(S_FL, 0, UBHW_LW, 0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_dout", dout, 0);
    @(posedge clk); #1 rst = 1'b0;
    op(S_LD, 32'h820, UBHW_LW, 0);
    chk("mid_rst_miss", hit, 0);
    op(S_FL, 0, UBHW_LW, 0);
    sweep_len(n);
    chk("refl_len", n, 32);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
